// File: rtl/uart_pkg.sv
// uart_pkg: baud timing defaults, counter width and FSM encoding shared by uart_rx and uart_tx
package uart_pkg;
  localparam int CNT_BAUD_MAX = 5207;
  localparam int CNT_HALF = CNT_BAUD_MAX / 2;
  localparam int CNT_W = 13;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] STOP = 2'd3;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer with a configurable reset value
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= {2{RST_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver; mid-bit sampling, one-cycle po_flag / frame_err pulses
module uart_rx
  import uart_pkg::*;
#(
  parameter int CNT_BAUD_MAX = uart_pkg::CNT_BAUD_MAX,
  parameter int CNT_HALF = CNT_BAUD_MAX / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err
);
  logic rx_sync, rx_hist, fall, strobe, wrap;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt_baud;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  uart_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_sync));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rx_hist <= 1'b1;
    else rx_hist <= rx_sync;
  assign fall = rx_hist & ~rx_sync;
  assign strobe = cnt_baud == CNT_W'(CNT_HALF);
  assign wrap = cnt_baud == CNT_W'(CNT_BAUD_MAX);
  // bit_cnt wraps 7->0 on the last data strobe, so a DATA wrap with bit_cnt==0 ends the byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt_baud <= '0;
      bit_cnt <= '0;
      shift_reg <= '0;
      po_data <= '0;
      po_flag <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      po_flag <= 1'b0;
      frame_err <= 1'b0;
      cnt_baud <= (state == IDLE || wrap) ? '0 : cnt_baud + 1'b1;
      case (state)
        IDLE: if (fall) state <= START;
        START:
          if (strobe && rx_sync) begin
            state <= IDLE;
            cnt_baud <= '0;
          end else if (wrap) begin
            state <= DATA;
            bit_cnt <= '0;
          end
        DATA: begin
          if (strobe) begin
            shift_reg[bit_cnt] <= rx_sync;
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (wrap && bit_cnt == '0) state <= STOP;
        end
        default:
          if (strobe) begin
            po_flag <= rx_sync;
            frame_err <= ~rx_sync;
            if (rx_sync) po_data <= shift_reg;
            state <= IDLE;
            cnt_baud <= '0;
          end
      endcase
    end
endmodule
